reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised 2-read/1-write register file with write-through bypass, per-register
//  pending-write scoreboard and a sequential clear-sweep FSM. Sits in the decode stage
//  of the pipelined datapath: serves operand reads, flags RAW hazards to the stall
//  logic, and accepts write-back from the final stage.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads as 0, ignores writes, never pending
//  BYPASS    1   1: same-cycle write data forwarded to matching read port
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  we        in   1       write enable (write-back)
//  wa        in   ADDR_W  write address
//  wd        in   DATA_W  write data
//  ra1, ra2  in   ADDR_W  read addresses
//  rd1, rd2  out  DATA_W  read data (combinational)
//  sb_set    in   1       issue: mark register sb_addr pending
//  sb_addr   in   ADDR_W  destination of issued instruction
//  hazard1   out  1       ra1 operand has an unresolved pending write
//  hazard2   out  1       ra2 operand has an unresolved pending write
//  clr       in   1       start clear sweep (pulse, sampled in IDLE only)
//  clr_busy  out  1       sweep in progress
// BEHAVIOUR
//  Reset (rst_n=0, async): all entries 0, all pending bits 0, FSM IDLE, sweep count 0;
//   hence rd1=rd2=0, hazard1=hazard2=0, clr_busy=0 while and after reset.
//  Write: posedge clk with we=1 and state IDLE -> mem[wa]<=wd, pending[wa]<=0.
//   ZERO_REG=1 and wa=0 -> write discarded.
//  Read: rdN = 0 if ZERO_REG and raN=0; else wd if BYPASS and we and wa==raN and IDLE;
//   else mem[raN]. Zero latency. BYPASS=0: new value visible cycle after write.
//  Scoreboard: posedge with sb_set=1 in IDLE -> pending[sb_addr]<=1 (ignored for addr 0
//   when ZERO_REG). Same cycle sb_set and we on same address: set wins (new producer).
//  hazardN = pending[raN] & ~(BYPASS & we & wa==raN) & ~(ZERO_REG & raN==0) & IDLE.
//  FSM: IDLE --clr=1--> CLEAR (count=0). CLEAR: each cycle mem[count]<=0,
//   pending[count]<=0, count++; at count==DEPTH-1 -> IDLE. Sweep = DEPTH cycles;
//   clr_busy=1 exactly those DEPTH cycles, 0 from the next.
//  During CLEAR: we, sb_set, clr ignored (no write, no set, no restart); bypass off;
//   reads return current array contents; hazards forced 0.
//  clr and we same cycle in IDLE: the write is performed, then the sweep erases it.
//  rst_n asserted mid-sweep: immediate return to reset state; sweep is not resumed.
//  Count wraps only via the DEPTH-1 terminal check; no overflow state.
// TESTING
//  1 Reset then read all 32 entries -> every rd1/rd2=0, hazards 0, clr_busy 0.
//  2 we=1 wa=3 wd=0xDEADBEEF, ra1=3 same cycle -> rd1=0xDEADBEEF (BYPASS=1); next
//    cycle with we=0 -> rd1=0xDEADBEEF; wa=0 wd=0x5 -> rd of r0 stays 0.
//  3 sb_set addr 7; next cycle ra2=7 -> hazard2=1; write wa=7 wd=0x12 -> hazard2=0 same
//    cycle, rd2=0x12; sb_set and we both addr 9 same edge -> hazard on 9 stays 1.
//  4 Fill r1..r31 with index, pend r5, pulse clr -> clr_busy high 32 cycles; we to r2
//    mid-sweep ignored; afterwards all entries 0, hazard on r5 = 0.
//  5 Start sweep, drop rst_n at cycle 10 -> clr_busy=0 asynchronously, all entries 0,
//    FSM IDLE after release; normal write/read works next cycle.
//  6 BYPASS=0, DATA_W=16, ADDR_W=3: write r4=0xA5A5 -> same-cycle rd=old 0, next=0xA5A5.

Source files
------------

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with write-through bypass, per-register pending-write
// scoreboard for RAW hazard detection, and a sequential clear-sweep FSM.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              clr,
  output logic              clr_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W-1:0] count;

  logic idle;
  logic wr_zero, sb_zero, rd1_zero, rd2_zero;
  logic byp1, byp2;

  assign idle     = (state == IDLE);
  assign wr_zero  = ZERO_REG && (wa == '0);
  assign sb_zero  = ZERO_REG && (sb_addr == '0);
  assign rd1_zero = ZERO_REG && (ra1 == '0);
  assign rd2_zero = ZERO_REG && (ra2 == '0);
  assign byp1     = BYPASS && idle && we && (wa == ra1);
  assign byp2     = BYPASS && idle && we && (wa == ra2);
  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (count == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scoreboard set is applied after the write-back clear so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pending <= '0;
      count   <= '0;
    end else if (idle) begin
      if (we && !wr_zero) begin
        mem[wa]     <= wd;
        pending[wa] <= 1'b0;
      end
      if (sb_set && !sb_zero) begin
        pending[sb_addr] <= 1'b1;
      end
      if (clr) begin
        count <= '0;
      end
    end else begin
      mem[count]     <= '0;
      pending[count] <= 1'b0;
      count          <= count + 1'b1;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    if (rd1_zero)  rd1 = '0;
    else if (byp1) rd1 = wd;
  end

  always_comb begin
    rd2 = mem[ra2];
    if (rd2_zero)  rd2 = '0;
    else if (byp2) rd2 = wd;
  end

  assign hazard1 = idle && pending[ra1] && !byp1 && !rd1_zero;
  assign hazard2 = idle && pending[ra2] && !byp2 && !rd2_zero;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against an array-based reference model,
// plus a small directed check of a 16-bit, 8-entry, no-bypass instance.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, sb_set, clr;
  logic [4:0]  wa, ra1, ra2, sb_addr;
  logic [31:0] wd;
  logic [31:0] rd1, rd2;
  logic        hazard1, hazard2, clr_busy;

  logic        b_we, b_sb_set, b_clr;
  logic [2:0]  b_wa, b_ra1, b_ra2, b_sb_addr;
  logic [15:0] b_wd, b_rd1, b_rd2;
  logic        b_hazard1, b_hazard2, b_clr_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_busy;
  int          m_sidx;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .sb_set(sb_set), .sb_addr(sb_addr),
    .hazard1(hazard1), .hazard2(hazard2), .clr(clr), .clr_busy(clr_busy)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .ra1(b_ra1), .ra2(b_ra2),
    .rd1(b_rd1), .rd2(b_rd2), .sb_set(b_sb_set), .sb_addr(b_sb_addr),
    .hazard1(b_hazard1), .hazard2(b_hazard2), .clr(b_clr), .clr_busy(b_clr_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (!m_busy && we && wa == ra) return wd;
    return m_mem[ra];
  endfunction

  function automatic logic exp_hz(input logic [4:0] ra);
    return !m_busy && m_pend[ra] && !(we && wa == ra) && ra != 5'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_sidx = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (sb_set && sb_addr != 5'd0) m_pend[sb_addr] = 1'b1;
      if (clr) begin
        m_busy = 1'b1;
        m_sidx = 0;
      end
    end else begin
      m_mem[m_sidx]  = 32'd0;
      m_pend[m_sidx] = 1'b0;
      m_sidx++;
      if (m_sidx == 32) m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_rd1"}, rd1, exp_rd(ra1));
    check({ph, "_rd2"}, rd2, exp_rd(ra2));
    check({ph, "_hz1"}, {31'd0, hazard1}, {31'd0, exp_hz(ra1)});
    check({ph, "_hz2"}, {31'd0, hazard2}, {31'd0, exp_hz(ra2)});
    check({ph, "_busy"}, {31'd0, clr_busy}, {31'd0, m_busy});
  endtask

  // Inputs must be set by the caller; outputs checked, then one clock edge applied.
  task automatic cycle(input string ph);
    #1;
    check_outputs(ph);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; sb_set = 0; sb_addr = 0; clr = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_ra1 = 0; b_ra2 = 0; b_sb_set = 0; b_sb_addr = 0; b_clr = 0;
  endtask

  task automatic read_all_zero(input string ph);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check({ph, "_z1"}, rd1, 32'd0);
      check({ph, "_z2"}, rd2, 32'd0);
      check({ph, "_zh"}, {30'd0, hazard1, hazard2}, 32'd0);
    end
  endtask

  initial begin
    int busy_n;
    idle_in();
    rst_n = 1'b0;
    model_reset();

    // Reset state: everything reads zero, no hazards, not busy
    #2;
    read_all_zero("t1");
    check("t1_busy", {31'd0, clr_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass and zero register
    we = 1; wa = 3; wd = 32'hDEADBEEF; ra1 = 3;
    #1 check("t2_byp", rd1, 32'hDEADBEEF);
    cycle("t2a");
    idle_in(); ra1 = 3;
    #1 check("t2_hold", rd1, 32'hDEADBEEF);
    cycle("t2b");
    we = 1; wa = 0; wd = 32'h5; ra1 = 0;
    cycle("t2c");
    idle_in();
    #1 check("t2_r0", rd1, 32'd0);
    cycle("t2d");

    // Scoreboard
    sb_set = 1; sb_addr = 7;
    cycle("t3a");
    idle_in(); ra2 = 7;
    #1 check("t3_hz_set", {31'd0, hazard2}, 32'd1);
    cycle("t3b");
    we = 1; wa = 7; wd = 32'h12; ra2 = 7;
    #1 check("t3_hz_byp", {31'd0, hazard2}, 32'd0);
    check("t3_rd_byp", rd2, 32'h12);
    cycle("t3c");
    idle_in(); sb_set = 1; sb_addr = 9; we = 1; wa = 9; wd = 32'h99;
    cycle("t3d");
    idle_in(); ra2 = 9;
    #1 check("t3_set_wins", {31'd0, hazard2}, 32'd1);
    cycle("t3e");

    // Fill, pend r5, sweep; a mid-sweep write must be dropped
    for (int i = 1; i < 32; i++) begin
      idle_in(); we = 1; wa = 5'(i); wd = 32'(i); ra1 = 5'(i); ra2 = 5'(i - 1);
      cycle("t4f");
    end
    idle_in(); sb_set = 1; sb_addr = 5;
    cycle("t4s");
    idle_in(); clr = 1;
    cycle("t4c");
    idle_in();
    busy_n = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!clr_busy) break;
      busy_n++;
      idle_in();
      ra1 = 5; ra2 = 2;
      if (n == 10) begin we = 1; wa = 2; wd = 32'h77; sb_set = 1; sb_addr = 6; clr = 1; end
      cycle("t4w");
    end
    idle_in();
    check("t4_busy_len", 32'(busy_n), 32'd32);
    read_all_zero("t4");
    ra1 = 5;
    #1 check("t4_hz5", {31'd0, hazard1}, 32'd0);

    // Reset in mid-sweep
    for (int i = 1; i < 32; i++) begin
      idle_in(); we = 1; wa = 5'(i); wd = 32'hA000_0000 + 32'(i);
      cycle("t5f");
    end
    idle_in(); clr = 1;
    cycle("t5c");
    idle_in();
    for (int n = 0; n < 10; n++) cycle("t5w");
    ra1 = 20; ra2 = 31;
    #1 check("t5_pre", rd1, 32'hA000_0014);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check("t5_busy_async", {31'd0, clr_busy}, 32'd0);
    read_all_zero("t5");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_idle", {31'd0, clr_busy}, 32'd0);
    idle_in(); we = 1; wa = 12; wd = 32'h1234_5678;
    cycle("t5n");
    idle_in(); ra1 = 12;
    #1 check("t5_rd", rd1, 32'h1234_5678);
    cycle("t5m");

    // No-bypass 16-bit instance
    b_we = 1; b_wa = 4; b_wd = 16'hA5A5; b_ra1 = 4;
    #1 check("t6_same", {16'd0, b_rd1}, 32'd0);
    cycle("t6a");
    idle_in(); b_ra1 = 4;
    #1 check("t6_next", {16'd0, b_rd1}, 32'h0000A5A5);
    b_sb_set = 1; b_sb_addr = 2;
    cycle("t6b");
    idle_in(); b_we = 1; b_wa = 2; b_wd = 16'h0042; b_ra2 = 2;
    #1 check("t6_hz_nobyp", {31'd0, b_hazard2}, 32'd1);
    check("t6_rd_old", {16'd0, b_rd2}, 32'd0);
    cycle("t6c");
    idle_in(); b_ra2 = 2;
    #1 check("t6_hz_clr", {31'd0, b_hazard2}, 32'd0);
    check("t6_rd_new", {16'd0, b_rd2}, 32'h00000042);
    cycle("t6d");

    // Random traffic including occasional sweeps
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      we      = ($urandom_range(0, 1) == 1);
      wa      = 5'($urandom_range(0, 31));
      wd      = $urandom;
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1     = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2     = ($urandom_range(0, 3) == 0) ? sb_addr : 5'($urandom_range(0, 31));
      clr     = ($urandom_range(0, 79) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
